// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, two write ports and a
// per-register pending (scoreboard) bit with a registered pending count.
module regfile_sb #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ZERO_HARD = 1,
    parameter int unsigned BYPASS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

    logic wa_we, wb_we, rsv_set;
    logic cnt_inc, wa_dec, wb_dec;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_HARD != 0) && (a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] stored);
        if (is_zero(a))                                  return '0;
        if ((BYPASS != 0) && wa_en && (wa_addr == a))    return wa_data;
        if ((BYPASS != 0) && wb_en && (wb_addr == a))    return wb_data;
        return stored;
    endfunction

    function automatic logic busy_of(input logic [ADDR_W-1:0] a, input logic pend);
        if ((BYPASS != 0) && ((wa_en && (wa_addr == a)) || (wb_en && (wb_addr == a))))
            return 1'b0;
        return pend;
    endfunction

    // Port B is suppressed when port A hits the same register, so only one
    // write (and at most one pending clear) lands per address per edge.
    always_comb begin
        wa_we   = wa_en && !is_zero(wa_addr);
        wb_we   = wb_en && !is_zero(wb_addr) && !(wa_we && (wb_addr == wa_addr));
        rsv_set = rsv_en && !is_zero(rsv_addr);

        cnt_inc = rsv_set && !pend_q[rsv_addr];
        wa_dec  = wa_we && pend_q[wa_addr] && !(rsv_set && (rsv_addr == wa_addr));
        wb_dec  = wb_we && pend_q[wb_addr] && !(rsv_set && (rsv_addr == wb_addr));

        regs_d = regs_q;
        if (wa_we) regs_d[wa_addr] = wa_data;
        if (wb_we) regs_d[wb_addr] = wb_data;

        pend_d = pend_q;
        if (wa_we)   pend_d[wa_addr]  = 1'b0;
        if (wb_we)   pend_d[wb_addr]  = 1'b0;
        if (rsv_set) pend_d[rsv_addr] = 1'b1;

        pend_cnt_d = pend_cnt_q + CNT_W'(cnt_inc) - CNT_W'(wa_dec) - CNT_W'(wb_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    always_comb begin
        rs_data  = rd_mux(rs_addr, regs_q[rs_addr]);
        rt_data  = rd_mux(rt_addr, regs_q[rt_addr]);
        rs_busy  = busy_of(rs_addr, pend_q[rs_addr]);
        rt_busy  = busy_of(rt_addr, pend_q[rt_addr]);
        pend_cnt = pend_cnt_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected read-port values
// from an array-based reference model; a negedge monitor pops and compares.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs_addr, rt_addr, wa_addr, wb_addr, rsv_addr;
    logic [DW-1:0] rs_data, rt_data, wa_data, wb_data;
    logic          rs_busy, rt_busy, wa_en, wb_en, rsv_en;
    logic [AW:0]   pend_cnt;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_HARD(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pend_cnt(pend_cnt)
    );

    typedef struct {
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        logic          rsb;
        logic          rtb;
        logic [AW:0]   cnt;
        int            step;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    logic [DW-1:0] mreg  [N];
    bit            mpend [N];

    // Reference model: spec rules expressed directly on arrays.
    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wa_en && wa_addr == a) return wa_data;
        if (wb_en && wb_addr == a) return wb_data;
        return mreg[a];
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] a);
        if ((wa_en && wa_addr == a) || (wb_en && wb_addr == a)) return 1'b0;
        return mpend[a];
    endfunction

    function automatic logic [AW:0] m_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) if (mpend[i]) c++;
        return (AW+1)'(c);
    endfunction

    task automatic idle();
        wa_en = 0; wb_en = 0; rsv_en = 0;
        wa_addr = '0; wb_addr = '0; rsv_addr = '0;
        wa_data = '0; wb_data = '0;
    endtask

    task automatic issue();
        exp_t e;
        e.rs   = m_read(rs_addr);
        e.rt   = m_read(rt_addr);
        e.rsb  = m_busy(rs_addr);
        e.rtb  = m_busy(rt_addr);
        e.cnt  = m_cnt();
        e.step = step_no++;
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) begin mreg[i] = '0; mpend[i] = 0; end
        end else begin
            if (wb_en && wb_addr != 0) begin mreg[wb_addr] = wb_data; mpend[wb_addr] = 0; end
            if (wa_en && wa_addr != 0) begin mreg[wa_addr] = wa_data; mpend[wa_addr] = 0; end
            if (rsv_en && rsv_addr != 0) mpend[rsv_addr] = 1;
        end
        #1;
    endtask

    task automatic chk(input string name, input int step, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rs_data",  e.step, 64'(rs_data),  64'(e.rs));
            chk("rt_data",  e.step, 64'(rt_data),  64'(e.rt));
            chk("rs_busy",  e.step, 64'(rs_busy),  64'(e.rsb));
            chk("rt_busy",  e.step, 64'(rt_busy),  64'(e.rtb));
            chk("pend_cnt", e.step, 64'(pend_cnt), 64'(e.cnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin mreg[i] = '0; mpend[i] = 0; end
        rst = 1; idle(); rs_addr = '0; rt_addr = '0;
        @(posedge clk); #1;
        issue();
        rst = 0;

        // Reset state read of every address
        for (int i = 0; i < N; i++) begin
            rs_addr = AW'(i); rt_addr = AW'(N - 1 - i);
            issue();
        end

        // Bypass of port A write
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rs_addr = 5; rt_addr = 6;
        issue(); idle(); issue();

        // Dual write to same address, port A wins
        wa_en = 1; wa_addr = 7; wa_data = 32'h11;
        wb_en = 1; wb_addr = 7; wb_data = 32'h22; rs_addr = 7; rt_addr = 7;
        issue(); idle(); issue();

        // Hard-zero register
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0;
        rs_addr = 0; rt_addr = 0;
        issue(); idle(); issue();

        // Reserve / release sequencing
        rsv_en = 1; rsv_addr = 3; rs_addr = 3; rt_addr = 4;
        issue(); idle();
        rsv_en = 1; rsv_addr = 4; wb_en = 1; wb_addr = 3; wb_data = 32'hA5A5;
        issue(); idle(); issue();
        rsv_en = 1; rsv_addr = 9; wa_en = 1; wa_addr = 9; wa_data = 32'h99; rs_addr = 9;
        issue(); idle(); issue();
        rsv_en = 1; rsv_addr = 9; issue(); idle(); issue();

        // Reset overrides a same-cycle write and a prior reservation
        rsv_en = 1; rsv_addr = 10; rs_addr = 10; issue(); idle();
        rst = 1; wa_en = 1; wa_addr = 10; wa_data = 32'h1234; issue();
        rst = 0; idle(); issue();

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            wa_en    = ($urandom_range(0, 2) == 0);
            wb_en    = ($urandom_range(0, 2) == 0);
            rsv_en   = ($urandom_range(0, 4) < 3);
            wa_addr  = AW'($urandom_range(0, N - 1));
            wb_addr  = ($urandom_range(0, 7) == 0) ? wa_addr : AW'($urandom_range(0, N - 1));
            rsv_addr = ($urandom_range(0, 7) == 0) ? wa_addr : AW'($urandom_range(0, N - 1));
            wa_data  = $urandom;
            wb_data  = $urandom;
            rs_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, N - 1));
            rt_addr  = ($urandom_range(0, 3) == 0) ? wb_addr : AW'($urandom_range(0, N - 1));
            issue();
        end
        rst = 0; idle();

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
